alu_rr_scheduler: RTL

//  Shares one ALU (ops: 0 clear, 1 add, 2 sub, 3 mul, 4 div; result width 2*DATA_WIDTH,

---
 rtl/alu_rr_scheduler.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler
//   Shares a single registered ALU between NUM_REQ requesters. Only one
//   operation is in flight at a time. Grants rotate round-robin, starting
//   from the index after the last grant. The result comes back tagged with
//   the id of the requester that issued it.
//
// Ports
//   clk, reset_n           clock and async active-low reset (the ALU uses the same reset)
//   req_valid/req_ready    per-requester handshake; req_ready is one-hot and only asserted in IDLE
//   req_a/req_b/req_oper   packed per-requester operands and opcode
//   alu_execute            single-cycle execute strobe
//   alu_oper/alu_a/alu_b   latched operation, driven from ISSUE through WAIT
//   alu_res                ALU result, registered one cycle after execute
//   rsp_valid/rsp_ready    response handshake
//   rsp_id/rsp_result/rsp_err  response payload, held stable while in RESP
//   busy                   high in every state except IDLE
module alu_rr_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b,
  input  logic [NUM_REQ*3-1:0]            req_oper,
  output logic                            alu_execute,
  output logic [2:0]                      alu_oper,
  output logic [DATA_WIDTH-1:0]           alu_a,
  output logic [DATA_WIDTH-1:0]           alu_b,
  input  logic [2*DATA_WIDTH-1:0]         alu_res,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [ID_W-1:0]                 rsp_id,
  output logic [2*DATA_WIDTH-1:0]         rsp_result,
  output logic                            rsp_err,
  output logic                            busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [2:0] OP_DIV = 3'd4;

  logic [1:0]              state_q,  state_d;
  logic [ID_W-1:0]         rr_q,     rr_d;
  logic [ID_W-1:0]         id_q,     id_d;
  logic [DATA_WIDTH-1:0]   a_q,      a_d;
  logic [DATA_WIDTH-1:0]   b_q,      b_d;
  logic [2:0]              oper_q,   oper_d;
  logic [2*DATA_WIDTH-1:0] result_q, result_d;
  logic                    err_q,    err_d;

  // Per-requester views of the packed operand buses
  logic [DATA_WIDTH-1:0] a_arr    [NUM_REQ];
  logic [DATA_WIDTH-1:0] b_arr    [NUM_REQ];
  logic [2:0]            oper_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g]    = req_a[g*DATA_WIDTH +: DATA_WIDTH];
    assign b_arr[g]    = req_b[g*DATA_WIDTH +: DATA_WIDTH];
    assign oper_arr[g] = req_oper[g*3 +: 3];
  end

  logic            found;
  logic [ID_W-1:0] gnt;
  logic [ID_W-1:0] idx;

  // Round-robin search: the first valid requester at or after rr_q, wrapping around
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((int'(rr_q) + int'(i)) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    oper_d      = oper_q;
    result_d    = result_q;
    err_d       = err_q;
    req_ready   = '0;
    alu_execute = 1'b0;
    alu_oper    = '0;
    alu_a       = '0;
    alu_b       = '0;
    rsp_valid   = 1'b0;
    rsp_id      = '0;
    rsp_result  = '0;
    rsp_err     = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          req_ready[gnt] = 1'b1;
          id_d   = gnt;
          a_d    = a_arr[gnt];
          b_d    = b_arr[gnt];
          oper_d = oper_arr[gnt];
          rr_d   = (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
          if (oper_arr[gnt] > OP_DIV) begin
            // Illegal opcode: the ALU is never touched, so reply at once
            result_d = '0;
            err_d    = 1'b1;
            state_d  = RESP;
          end else begin
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: begin
        alu_execute = 1'b1;
        alu_oper    = oper_q;
        alu_a       = a_q;
        alu_b       = b_q;
        state_d     = WAIT;
      end
      WAIT: begin
        alu_oper = oper_q;
        alu_a    = a_q;
        alu_b    = b_q;
        result_d = alu_res;
        err_d    = (oper_q == OP_DIV) && (b_q == '0);
        state_d  = RESP;
      end
      RESP: begin
        rsp_valid  = 1'b1;
        rsp_id     = id_q;
        rsp_result = result_q;
        rsp_err    = err_q;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      oper_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      oper_q   <= oper_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

endmodule
